mac_result_drain: RTL and testbench
===================================

Name: mac_result_drain

Overview:
- Sits directly downstream of the 32x32 MAC array.
- Consumes the array's full flat product vector once per cycle and accumulates each 16-bit product into a per-cell accumulator over a tile of K beats (K set by in_last).
- Then drains the accumulators one row per beat over a valid/ready stream to the writeback path.
- Single clock; accepts no new input while draining.

Parameters:
- ROWS, 32, array rows
- COLS, 32, array columns
- PW, 16, product width per cell
- AW, 24, accumulator width per cell (AW >= PW)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  product vector valid
- in_ready  output  1  block can accept a product vector
- in_result  input  ROWS*COLS*PW  products; cell (r,c) at [(r*COLS+c)*PW +: PW]
- in_last  input  1  qualifies the final beat of a tile
- out_valid  output  1  drain row valid
- out_ready  input  1  downstream accepts row
- out_data  output  COLS*AW  row accumulators; column c at [c*AW +: AW]
- out_row  output  $clog2(ROWS)  row index of out_data
- out_last  output  1  high with the final row (ROWS-1)
- sat_flag  output  1  sticky: some accumulator saturated in the current/draining tile

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- States: ACCUM, DRAIN. Reset -> ACCUM.
- Reset values: first_beat=1, row_idx=0, out_valid=0, out_last=0, sat_flag=0, in_ready=1. out_data/out_row are driven 0 whenever out_valid=0. Accumulator storage is not cleared.

ACCUM:
- in_ready=1.
- On in_valid&in_ready, for every cell: acc = first_beat ? zero-extend(product) : acc + product. All arithmetic is unsigned.
- If the sum exceeds 2^AW-1, acc <= 2^AW-1 and sat_flag <= 1.
- first_beat <= 0 after an accepted beat.
- An accepted beat with in_last=1 -> DRAIN next cycle, row_idx=0.
- in_last while in_valid=0 is ignored.

DRAIN:
- in_ready=0; in_valid is ignored (never accepted or accumulated).
- out_valid=1, out_row=row_idx, out_data=acc[row_idx][*], out_last=(row_idx==ROWS-1).
- On out_valid&out_ready: row_idx++.
- If out_last is also set on that handshake -> ACCUM with first_beat=1, row_idx=0.
- out_valid low -> no row output.
- Outputs hold stable while out_ready=0.

sat_flag:
- Cleared on the first accepted beat of a new tile (before that beat's own saturation is OR'd in).
- Held through DRAIN.

Latency and boundary conditions:
- Beat with in_last accepted at cycle N -> out_valid=1, row 0 at N+1. Minimum drain is ROWS cycles.
- The cycle after the final drain handshake, in_ready=1. A beat accepted then loads rather than adds, with no stale carry-over.
- Reset mid-ACCUM or mid-DRAIN: the next cycle is ACCUM with first_beat=1. The partial tile is discarded and the next tile is unaffected by stale accumulators.
- Single-beat tile (first beat has in_last): acc = product.
- No beat-count limit; saturation is the only overflow response.

Optional Feature:
- MAC_DRAIN_PARITY_EN defined: adds output out_parity [COLS-1:0].
  - Bit c = XOR-reduction of out_data[c*AW +: AW] (even parity).
  - Valid with out_valid; 0 when out_valid=0 and at reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- 1-beat tile, all products 3, in_last=1, out_ready=1 -> 32 beats at out_row 0..31 on consecutive cycles, every field = 3, out_last only at row 31, sat_flag=0.
- 4-beat tile, product(r,c)=r+c -> acc(r,c)=4(r+c). Row 5 column 7 = 48; row 31 column 31 = 248.
- 300 beats of 0xFFFF (AW=24): 19,660,500 > 16,777,215 -> all fields 0xFFFFFF, sat_flag=1 during drain. Next tile of 1 beat of 1 -> sat_flag=0, fields=1.
- Drain with out_ready low 10 cycles at row 3, in_valid=1 throughout -> out_row/out_data stable at row 3, in_ready=0, no extra accumulation. Following tile starts clean.
- rst pulsed at drain row 12 -> next cycle out_valid=0, out_data=0, in_ready=1, sat_flag=0. A 1-beat tile of 7 then drains all fields = 7.
- in_valid held high across the out_last handshake -> beat accepted the very next cycle is loaded (not added). With MAC_DRAIN_PARITY_EN defined, out_parity matches the XOR of each field.

Source files
------------

// File: rtl/mac_result_drain.sv
// mac_result_drain
// ----------------
// Accumulates the flat product vector of the MAC array into a per-cell
// accumulator over a tile of beats, then streams the accumulators out one
// row per beat. No input is accepted while a tile is being drained.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   product vector valid
//   in_ready   high in ACCUM: block takes a product vector this cycle
//   in_result  products, cell (r,c) at [(r*COLS+c)*PW +: PW]
//   in_last    marks the final beat of a tile (ignored unless in_valid)
//   out_valid  drain row valid
//   out_ready  downstream accepts the row
//   out_data   row accumulators, column c at [c*AW +: AW]
//   out_row    row index of out_data
//   out_last   high with row ROWS-1
//   sat_flag   sticky: some accumulator saturated in the current tile
//   out_parity (only with MAC_DRAIN_PARITY_EN) even parity per column field
//
// Optional feature macro: MAC_DRAIN_PARITY_EN
module mac_result_drain #(
    parameter int ROWS = 32,
    parameter int COLS = 32,
    parameter int PW   = 16,
    parameter int AW   = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*COLS*PW-1:0]   in_result,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*AW-1:0]        out_data,
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic                      out_last,
`ifdef MAC_DRAIN_PARITY_EN
    output logic [COLS-1:0]           out_parity,
`endif
    output logic                      sat_flag
);

    localparam int RW = $clog2(ROWS);
    localparam int SW = AW + 1;   // one carry bit to detect overflow

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                          state, state_d;
    logic                            first_beat;
    logic [RW-1:0]                   row_idx;
    logic                            accept;
    logic                            drain_hs;
    logic [ROWS*COLS-1:0]            cell_sat;
    logic [ROWS-1:0][COLS*AW-1:0]    acc_rows;

    assign accept   = in_valid & in_ready;
    assign drain_hs = out_valid & out_ready;

    // Per-cell accumulator. Storage is never cleared: the first beat of a
    // tile loads instead of adding, which discards any stale contents.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [PW-1:0] prod;
            logic [AW-1:0] acc_cell;
            logic [SW-1:0] sum;

            assign prod = in_result[(r*COLS+c)*PW +: PW];
            assign sum  = first_beat ? SW'(prod) : ({1'b0, acc_cell} + SW'(prod));
            assign cell_sat[r*COLS+c]     = sum[AW];
            assign acc_rows[r][c*AW +: AW] = acc_cell;

            always_ff @(posedge clk) begin
                if (accept)
                    acc_cell <= sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            first_beat <= 1'b1;
            row_idx    <= '0;
            sat_flag   <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                first_beat <= 1'b0;
                // A new tile drops the old flag before OR-ing in its own beat.
                sat_flag   <= (sat_flag & ~first_beat) | (|cell_sat);
                if (in_last)
                    row_idx <= '0;
            end
            if (drain_hs) begin
                if (out_last) begin
                    row_idx    <= '0;
                    first_beat <= 1'b1;
                end else begin
                    row_idx <= row_idx + RW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_row   = '0;
        out_data  = '0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_row   = row_idx;
                out_data  = acc_rows[row_idx];
                out_last  = (row_idx == RW'(ROWS-1));
                if (out_ready && out_last)
                    state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

`ifdef MAC_DRAIN_PARITY_EN
    // out_data is already zero when idle, so parity is zero then too.
    for (genvar c = 0; c < COLS; c++) begin : g_par
        assign out_parity[c] = ^out_data[c*AW +: AW];
    end
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// Randomized scoreboard bench for mac_result_drain. A driver issues tiles and
// pushes the rows a tile must drain into a queue; a monitor on the falling
// edge compares every presented row against the queue front.
module tb_mac_result_drain;

    localparam int ROWS = 32;
    localparam int COLS = 32;
    localparam int PW   = 16;
    localparam int AW   = 24;
    localparam int RW   = $clog2(ROWS);
    localparam longint AMAX = (longint'(1) << AW) - 1;

    typedef struct {
        logic [COLS*AW-1:0] data;
        logic [RW-1:0]      row;
        logic               last;
        logic               sat;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*COLS*PW-1:0] in_result;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*AW-1:0]      out_data;
    logic [RW-1:0]           out_row;
    logic                    out_last;
    logic                    sat_flag;
`ifdef MAC_DRAIN_PARITY_EN
    logic [COLS-1:0]         out_parity;
`endif

    mac_result_drain #(.ROWS(ROWS), .COLS(COLS), .PW(PW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
`ifdef MAC_DRAIN_PARITY_EN
        .out_parity(out_parity),
`endif
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    exp_t   q[$];
    longint acc_m [ROWS][COLS];
    longint prod  [ROWS][COLS];
    bit     m_first = 1'b1;
    bit     m_sat   = 1'b0;

    task automatic chk(input string name, input logic [COLS*AW-1:0] act,
                       input logic [COLS*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: whenever rows are owed, the DUT must be presenting
    // the queue front (held steady while out_ready is low).
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0) begin
                chk("out_valid", out_valid, 1);
                if (out_valid) begin
                    chk("out_row",  out_row,  q[0].row);
                    chk("out_data", out_data, q[0].data);
                    chk("out_last", out_last, q[0].last);
                    chk("sat_flag", sat_flag, q[0].sat);
`ifdef MAC_DRAIN_PARITY_EN
                    begin
                        logic [COLS-1:0] ep;
                        for (int c = 0; c < COLS; c++) ep[c] = ^q[0].data[c*AW +: AW];
                        chk("out_parity", out_parity, ep);
                    end
`endif
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                chk("idle_out_valid", out_valid, 0);
                chk("idle_out_data",  out_data,  0);
                chk("idle_out_row",   out_row,   0);
                chk("idle_out_last",  out_last,  0);
`ifdef MAC_DRAIN_PARITY_EN
                chk("idle_out_parity", out_parity, 0);
`endif
            end
        end
    end

    task automatic fill(input int mode, input int cval);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                case (mode)
                    1:       prod[r][c] = cval;
                    2:       prod[r][c] = r + c;
                    default: prod[r][c] = $urandom_range(0, 65535);
                endcase
                in_result[(r*COLS+c)*PW +: PW] = PW'(prod[r][c]);
            end
    endtask

    // Reference: load on first beat, add otherwise, clamp at 2^AW-1.
    task automatic model_beat(input bit last);
        if (m_first) m_sat = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                longint s;
                s = m_first ? prod[r][c] : acc_m[r][c] + prod[r][c];
                if (s > AMAX) begin
                    s = AMAX;
                    m_sat = 1'b1;
                end
                acc_m[r][c] = s;
            end
        m_first = 1'b0;
        if (last) begin
            for (int r = 0; r < ROWS; r++) begin
                exp_t e;
                for (int c = 0; c < COLS; c++) e.data[c*AW +: AW] = AW'(acc_m[r][c]);
                e.row  = RW'(r);
                e.last = (r == ROWS-1);
                e.sat  = m_sat;
                q.push_back(e);
            end
            m_first = 1'b1;
        end
    endtask

    task automatic run_tile(input int k, input int mode, input int cval, input bit gaps);
        for (int b = 0; b < k; b++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom % 2);
                fill(0, 0);
                @(negedge clk);
                chk("in_ready_idle", in_ready, 1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_last  = (b == k-1);
            fill(mode, cval);
            @(negedge clk);
            chk("in_ready_accum", in_ready, 1);
            @(posedge clk);
            model_beat(b == k-1);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Keeps in_valid high with junk during the drain; optional stall at one
    // row and optional reset when a given row is presented.
    task automatic drain(input int stall_row, input int rst_row, input bit rnd_ready);
        int guard = 0;
        int stalled = 0;
        while (q.size() > 0) begin
            if (guard++ > 5000) begin
                errors++;
                checks++;
                $display("FAIL drain_timeout rows_left=%0d expected=0", q.size());
                q.delete();
                break;
            end
            if (rst_row >= 0 && int'(q[0].row) == rst_row) begin
                rst = 1'b1;
                in_valid = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                q.delete();
                m_first = 1'b1;
                m_sat = 1'b0;
                @(negedge clk);
                chk("rst_in_ready",  in_ready,  1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data",  out_data,  0);
                chk("rst_sat_flag",  sat_flag,  0);
                @(posedge clk); #1;
                break;
            end
            in_valid = 1'b1;
            in_last  = 1'($urandom % 2);
            fill(0, 0);
            if (stall_row >= 0 && int'(q[0].row) == stall_row && stalled < 10) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = rnd_ready ? ($urandom % 4 != 0) : 1'b1;
            end
            @(negedge clk);
            chk("in_ready_drain", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_result = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  in_ready,  1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last",  out_last,  0);
        chk("reset_sat_flag",  sat_flag,  0);
        chk("reset_out_data",  out_data,  0);
        @(posedge clk); #1;

        run_tile(1, 1, 3, 0);          drain(-1, -1, 0);   // single beat, all 3
        run_tile(4, 2, 0, 0);          drain(-1, -1, 0);   // acc = 4(r+c)
        run_tile(300, 1, 'hFFFF, 0);   drain(-1, -1, 1);   // saturates
        run_tile(1, 1, 1, 0);          drain(-1, -1, 0);   // flag clears
        run_tile(3, 0, 0, 1);          drain(3, -1, 0);    // stall at row 3
        run_tile(2, 0, 0, 1);          drain(-1, -1, 1);
        run_tile(2, 0, 0, 0);          drain(-1, 12, 0);   // reset at row 12
        run_tile(1, 1, 7, 0);          drain(-1, -1, 0);
        for (int t = 0; t < 6; t++) begin
            run_tile($urandom_range(1, 5), 0, 0, 1);
            drain(-1, -1, 1);
        end
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
